// File: rtl/ldb_engine.sv
// ldb_engine: executes one load-to-buffer micro-instruction. It reads 32-bit
// GR words over an AXI-Lite read master, one read outstanding at a time, and
// deposits the bytes selected by byte_strb into per-SMC UR buffers. A second
// command arriving while busy waits in a 1-deep pending slot.
module ldb_engine #(
  parameter int unsigned PARAM_UR_BYTE_CNT   = 16,
  parameter int unsigned PARAM_GR_INTLV_ADDR = 64,
  parameter int unsigned PARAM_SMC_CNT       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [5:0]  smc_strb,
  input  logic [3:0]  byte_strb,
  input  logic [15:0] brst,
  input  logic [31:0] gr_base_addr,
  input  logic [1:0]  smc_id,
  input  logic [7:0]  ur_id,
  input  logic [15:0] ur_addr,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic        done,
  output logic        vld_down
);

  localparam int unsigned WORD_CNT = PARAM_UR_BYTE_CNT / 4;
  localparam logic [5:0]  SMC_MASK = 6'((1 << PARAM_SMC_CNT) - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  typedef struct packed {
    logic [5:0]  smc;
    logic [3:0]  bstrb;
    logic [15:0] brst;
    logic [31:0] base;
    logic [1:0]  smc_id;
    logic [7:0]  ur_id;
    logic [15:0] ur_addr;
  } cmd_t;

  state_t      state_q, state_d;
  cmd_t        cmd_q, pend_q, in_cmd, start_cmd;
  logic        pend_vld_q, active_q, active_d;
  logic        launch, load_cmd, pend_take, pend_fill, beat_wr;
  logic [2:0]  smc_q, smc_d;
  logic [15:0] beat_q, beat_d, widx;
  logic [31:0] araddr_d;
  logic [3:0]  first, nxt;

  logic [PARAM_SMC_CNT-1:0][WORD_CNT-1:0][31:0] ur_buf;

  // Lowest set SMC bit at or above index 'from': {found, index}.
  function automatic logic [3:0] find_smc(input logic [5:0] mask, input logic [2:0] from);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 0; i < PARAM_SMC_CNT; i++) begin
      if (!r[3] && mask[i] && (i >= 32'(from))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // GR byte address of beat k of SMC s, modulo 2^32.
  function automatic logic [31:0] gr_addr(input logic [31:0] base, input logic [2:0] s,
                                          input logic [15:0] k);
    return base + (32'(s) * PARAM_GR_INTLV_ADDR) + {14'd0, k, 2'b00};
  endfunction

  // Next-state, traversal counters, next read address and command bookkeeping.
  always_comb begin
    in_cmd    = '{smc: smc_strb & SMC_MASK, bstrb: byte_strb, brst: brst, base: gr_base_addr,
                  smc_id: smc_id, ur_id: ur_id, ur_addr: ur_addr};
    state_d   = state_q;
    smc_d     = smc_q;
    beat_d    = beat_q;
    araddr_d  = axi_araddr;
    active_d  = active_q;
    start_cmd = in_cmd;
    launch    = 1'b0;
    load_cmd  = 1'b0;
    pend_take = 1'b0;
    first     = '0;
    nxt       = '0;
    beat_wr   = 1'b0;
    widx      = beat_q % 16'(WORD_CNT);

    case (state_q)
      IDLE: if (vld) launch = 1'b1;
      AR:   if (axi_arready) state_d = R;
      R: begin
        if (axi_rvalid) begin
          beat_wr = 1'b1;
          if (beat_q + 16'd1 < cmd_q.brst) begin
            beat_d   = beat_q + 16'd1;
            araddr_d = gr_addr(cmd_q.base, smc_q, beat_q + 16'd1);
            state_d  = AR;
          end else begin
            nxt = find_smc(cmd_q.smc, smc_q + 3'd1);
            if (nxt[3]) begin
              smc_d    = nxt[2:0];
              beat_d   = '0;
              araddr_d = gr_addr(cmd_q.base, nxt[2:0], 16'd0);
              state_d  = AR;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        // A waiting command starts straight out of DONE; a vld landing in DONE
        // with an empty slot starts directly instead of stranding in the slot.
        if (pend_vld_q) begin
          start_cmd = pend_q;
          pend_take = 1'b1;
          launch    = 1'b1;
        end else if (vld) begin
          launch = 1'b1;
        end else begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      load_cmd = 1'b1;
      active_d = 1'b1;
      first    = find_smc(start_cmd.smc, 3'd0);
      if (!first[3] || (start_cmd.brst == 16'd0)) begin
        state_d = DONE;
      end else begin
        smc_d    = first[2:0];
        beat_d   = '0;
        araddr_d = gr_addr(start_cmd.base, first[2:0], 16'd0);
        state_d  = AR;
      end
    end

    pend_fill = vld && active_q && !pend_vld_q && (state_q != DONE);
  end

  // State, command, pending slot and registered AXI/completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      active_q    <= 1'b0;
      smc_q       <= '0;
      beat_q      <= '0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      done        <= 1'b0;
      vld_down    <= 1'b0;
    end else begin
      state_q     <= state_d;
      smc_q       <= smc_d;
      beat_q      <= beat_d;
      active_q    <= active_d;
      axi_araddr  <= araddr_d;
      axi_arvalid <= (state_d == AR);
      axi_rready  <= (state_d == R);
      done        <= (state_d == DONE);
      vld_down    <= (state_d == DONE);
      if (load_cmd) cmd_q <= start_cmd;
      if (pend_take) begin
        pend_vld_q <= 1'b0;
      end else if (pend_fill) begin
        pend_vld_q <= 1'b1;
        pend_q     <= in_cmd;
      end
    end
  end

  // UR buffer byte-lane writes for each accepted read beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ur_buf <= '0;
    end else if (beat_wr) begin
      for (int unsigned s = 0; s < PARAM_SMC_CNT; s++) begin
        for (int unsigned w = 0; w < WORD_CNT; w++) begin
          for (int unsigned i = 0; i < 4; i++) begin
            if ((smc_q == 3'(s)) && (widx == 16'(w)) && cmd_q.bstrb[i])
              ur_buf[s][w][8*i +: 8] <= axi_rdata[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ldb_engine.sv
// Self-checking bench for ldb_engine: AXI-Lite read slave with optional
// stalls and spurious rvalid, a command-level model of addresses and UR
// buffer contents, and directed scenarios with literal expectations.
module tb_ldb_engine;

  localparam int unsigned BC = 16;
  localparam int unsigned IL = 64;
  localparam int unsigned SC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic [5:0]  smc_strb = '0;
  logic [3:0]  byte_strb = '0;
  logic [15:0] brst = '0;
  logic [31:0] gr_base_addr = '0;
  logic [1:0]  smc_id = '0;
  logic [7:0]  ur_id = '0;
  logic [15:0] ur_addr = '0;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        done;
  logic        vld_down;

  always #5 clk = ~clk;

  ldb_engine #(.PARAM_UR_BYTE_CNT(BC), .PARAM_GR_INTLV_ADDR(IL), .PARAM_SMC_CNT(SC)) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .smc_strb(smc_strb), .byte_strb(byte_strb),
    .brst(brst), .gr_base_addr(gr_base_addr), .smc_id(smc_id), .ur_id(ur_id),
    .ur_addr(ur_addr), .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .done(done), .vld_down(vld_down)
  );

  typedef struct {
    logic [5:0]  smc;
    logic [3:0]  bs;
    logic [15:0] brst;
    logic [31:0] base;
  } cmd_t;

  int          errors = 0;
  int          checks = 0;
  int          done_total = 0;
  int          mem_mode = 0;
  bit          stall_en = 0;
  bit          spur_en = 0;
  cmd_t        cmdq[$];
  logic [31:0] expq[$];
  logic [31:0] arlog[$];
  logic [31:0] lit[$];
  logic [7:0]  mbuf [SC][BC];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (mem_mode == 0) ? (a >> 2) + 32'd1 : (32'hCAFE0000 | (a >> 2));
  endfunction

  function automatic logic [BC*8-1:0] mvec(input int unsigned s);
    logic [BC*8-1:0] v;
    for (int unsigned j = 0; j < BC; j++) v[8*j +: 8] = mbuf[s][j];
    return v;
  endfunction

  task automatic model_clear();
    for (int unsigned s = 0; s < SC; s++)
      for (int unsigned j = 0; j < BC; j++) mbuf[s][j] = 8'h00;
  endtask

  task automatic model_apply(input cmd_t c);
    logic [31:0] a, d;
    int unsigned lane;
    for (int unsigned s = 0; s < SC; s++) begin
      if (c.smc[s]) begin
        for (int unsigned k = 0; k < 32'(c.brst); k++) begin
          a = c.base + s * IL + k * 4;
          d = mem(a);
          lane = (4 * k) % BC;
          for (int unsigned i = 0; i < 4; i++)
            if (c.bs[i]) mbuf[s][lane + i] = d[8*i +: 8];
        end
      end
    end
  endtask

  task automatic check_bufs(input string tag);
    for (int unsigned s = 0; s < SC; s++)
      chk($sformatf("%s_ur_buf%0d", tag, s), 128'(dut.ur_buf[s]), 128'(mvec(s)));
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_ar_count"}, 128'(arlog.size()), 128'(lit.size()));
    for (int i = 0; i < lit.size() && i < arlog.size(); i++)
      chk($sformatf("%s_ar%0d", tag, i), 128'(arlog[i]), 128'(lit[i]));
  endtask

  // Drive one vld strobe; the bench decides acceptance from its own queue.
  task automatic issue(input logic [5:0] s, input logic [3:0] bs, input logic [15:0] b,
                       input logic [31:0] base, input logic [1:0] id);
    cmd_t c;
    @(negedge clk); #1;
    smc_strb = s; byte_strb = bs; brst = b; gr_base_addr = base; smc_id = id;
    ur_id = {6'd0, id} + 8'd10; ur_addr = 16'($urandom);
    vld = 1'b1;
    c.smc = s & 6'((1 << SC) - 1); c.bs = bs; c.brst = b; c.base = base;
    if (cmdq.size() < 2) begin
      cmdq.push_back(c);
      for (int unsigned q = 0; q < SC; q++)
        if (c.smc[q])
          for (int unsigned k = 0; k < 32'(b); k++) expq.push_back(base + q * IL + k * 4);
    end
    @(negedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 3000 && cmdq.size() != 0; n++) @(negedge clk);
    chk("idle_timeout", 128'(cmdq.size() == 0), 128'(1));
    repeat (3) @(negedge clk);
  endtask

  // Completion checker: every done must match an accepted command.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("vld_down_eq_done", 128'(vld_down), 128'(done));
        if (done) begin
          done_total++;
          chk("done_expected", 128'(cmdq.size() != 0), 128'(1));
          if (cmdq.size() != 0) begin
            c = cmdq.pop_front();
            model_apply(c);
            check_bufs("done");
          end
        end
      end
    end
  end

  // AXI-Lite read slave plus per-cycle protocol checks.
  initial begin
    bit          have_req = 0, pred_ar = 0, pred_r = 0, hold = 0;
    logic [31:0] req_addr = '0, pred_addr = '0, hold_addr = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_req = 0; pred_ar = 0; pred_r = 0; hold = 0;
        axi_arready = 1'b0; axi_rvalid = 1'b0;
      end else begin
        if (pred_r) have_req = 0;
        if (pred_ar) begin have_req = 1; req_addr = pred_addr; end
        if (hold) begin
          chk("ar_hold_valid", 128'(axi_arvalid), 128'(1));
          chk("ar_hold_addr", 128'(axi_araddr), 128'(hold_addr));
        end
        chk("rready_iff_outstanding", 128'(axi_rready), 128'(have_req));
        chk("single_outstanding", 128'(axi_arvalid && have_req), 128'(0));
        axi_arready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        pred_ar = axi_arvalid && axi_arready;
        if (pred_ar) begin
          pred_addr = axi_araddr;
          arlog.push_back(axi_araddr);
          chk("ar_expected", 128'(expq.size() != 0), 128'(1));
          if (expq.size() != 0) chk("araddr", 128'(axi_araddr), 128'(expq.pop_front()));
        end
        hold = axi_arvalid && !axi_arready;
        hold_addr = axi_araddr;
        if (have_req) begin
          axi_rvalid = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
          axi_rdata  = mem(req_addr);
        end else begin
          axi_rvalid = spur_en ? ($urandom_range(0, 1) == 1) : 1'b0;
          axi_rdata  = $urandom;
        end
        pred_r = have_req && axi_rvalid && axi_rready;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_araddr", 128'(axi_araddr), 128'(0));
    chk("rst_arvalid", 128'(axi_arvalid), 128'(0));
    chk("rst_rready", 128'(axi_rready), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_vld_down", 128'(vld_down), 128'(0));
    check_bufs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single SMC, four beats, first AR the cycle after vld.
    arlog.delete(); d0 = done_total;
    issue(6'b000001, 4'hF, 16'd4, 32'h0, 2'd0);
    chk("latency_ar", 128'(axi_arvalid), 128'(1));
    wait_idle();
    lit = '{32'h0, 32'h4, 32'h8, 32'hC};
    check_log("single");
    chk("single_buf0", 128'(dut.ur_buf[0]), 128'h00000004_00000003_00000002_00000001);
    chk("single_dones", 128'(done_total - d0), 128'(1));

    // Byte mask: prime word 0 with full strobes, then overwrite bytes 0-1 only.
    mem_mode = 1;
    issue(6'b000001, 4'hF, 16'd1, 32'd512, 2'd0);
    wait_idle();
    mem_mode = 0;
    issue(6'b000001, 4'b0011, 16'd1, 32'd512, 2'd0);
    wait_idle();
    chk("bytemask_buf0", 128'(dut.ur_buf[0]), 128'h00000004_00000003_00000002_CAFE0081);

    // Multi SMC: one done only after all six beats.
    arlog.delete(); d0 = done_total;
    issue(6'b000111, 4'hF, 16'd2, 32'd256, 2'd1);
    wait_idle();
    lit = '{32'h100, 32'h104, 32'h140, 32'h144, 32'h180, 32'h184};
    check_log("multi");
    chk("multi_dones", 128'(done_total - d0), 128'(1));

    // Sparse mask: SMC1 untouched.
    arlog.delete();
    issue(6'b000101, 4'hF, 16'd1, 32'd768, 2'd2);
    wait_idle();
    lit = '{32'h300, 32'h380};
    check_log("sparse");
    chk("sparse_buf1", 128'(dut.ur_buf[1]), 128'h00000000_00000000_00000052_00000051);

    // Back-to-back: second command pended two cycles after the first.
    arlog.delete(); d0 = done_total;
    issue(6'b000001, 4'hF, 16'd2, 32'h400, 2'd0);
    issue(6'b001000, 4'hF, 16'd1, 32'h400, 2'd3);
    wait_idle();
    lit = '{32'h400, 32'h404, 32'h4C0};
    check_log("b2b");
    chk("b2b_dones", 128'(done_total - d0), 128'(2));

    // Third command while the pending slot is full is dropped.
    arlog.delete(); d0 = done_total;
    issue(6'b000001, 4'hF, 16'd3, 32'h1000, 2'd0);
    issue(6'b000010, 4'hF, 16'd1, 32'h2000, 2'd1);
    issue(6'b000100, 4'hF, 16'd1, 32'h3000, 2'd2);
    wait_idle();
    lit = '{32'h1000, 32'h1004, 32'h1008, 32'h2040};
    check_log("drop");
    chk("drop_dones", 128'(done_total - d0), 128'(2));

    // More beats than buffer words: lanes wrap around.
    issue(6'b000010, 4'hF, 16'd6, 32'h0, 2'd1);
    wait_idle();
    chk("wrap_buf1", 128'(dut.ur_buf[1]), 128'h00000014_00000013_00000016_00000015);

    // Empty commands: no mask, mask bits above SMC count only, zero bursts.
    arlog.delete(); d0 = done_total;
    issue(6'b000000, 4'hF, 16'd3, 32'h0, 2'd0);
    chk("empty_done_latency", 128'(done), 128'(1));
    wait_idle();
    issue(6'b110000, 4'hF, 16'd3, 32'h0, 2'd0);
    wait_idle();
    issue(6'b000001, 4'hF, 16'd0, 32'h0, 2'd0);
    wait_idle();
    chk("empty_no_ar", 128'(arlog.size()), 128'(0));
    chk("empty_dones", 128'(done_total - d0), 128'(3));

    // Stalls and spurious rvalid, including address wrap past 2^32.
    stall_en = 1; spur_en = 1; d0 = done_total;
    issue(6'b000111, 4'b1010, 16'd5, 32'h0001_0000, 2'd0);
    wait_idle();
    issue(6'b000011, 4'b0101, 16'd2, 32'hFFFF_FFC0, 2'd1);
    issue(6'b001001, 4'hF, 16'd3, 32'h0002_0000, 2'd2);
    wait_idle();
    repeat (40) @(negedge clk);
    check_bufs("stress");
    chk("stress_dones", 128'(done_total - d0), 128'(3));

    // Reset mid-operation clears buffers and the pending command.
    issue(6'b001111, 4'hF, 16'd4, 32'h5000, 2'd0);
    issue(6'b000001, 4'hF, 16'd1, 32'h6000, 2'd1);
    repeat (6) @(negedge clk);
    #1;
    rst_n = 1'b0;
    cmdq.delete(); expq.delete(); model_clear();
    #1;
    chk("midrst_arvalid", 128'(axi_arvalid), 128'(0));
    chk("midrst_rready", 128'(axi_rready), 128'(0));
    chk("midrst_araddr", 128'(axi_araddr), 128'(0));
    check_bufs("midrst");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    stall_en = 0; spur_en = 0;
    arlog.delete(); d0 = done_total;
    repeat (20) @(negedge clk);
    chk("postrst_quiet", 128'(arlog.size()), 128'(0));
    issue(6'b000100, 4'hF, 16'd1, 32'h7000, 2'd2);
    wait_idle();
    lit = '{32'h7080};
    check_log("postrst");
    chk("postrst_dones", 128'(done_total - d0), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
